// File: rtl/picoramsoc_mailbox_pkg.sv
// Shared definitions for the picoramsoc mailbox: register map, STATUS/CTRL
// bit positions and the bus-side state encoding.
package picoramsoc_mailbox_pkg;

  localparam logic [3:0] MBOX_DATA   = 4'h0;
  localparam logic [3:0] MBOX_STATUS = 4'h4;
  localparam logic [3:0] MBOX_CTRL   = 4'h8;

  localparam int unsigned STAT_RX_NONEMPTY = 0;
  localparam int unsigned STAT_TX_FULL     = 1;
  localparam int unsigned STAT_IRQ_EN      = 2;
  localparam int unsigned STAT_TX_OVF      = 3;
  localparam int unsigned STAT_RX_COUNT    = 8;
  localparam int unsigned STAT_TX_COUNT    = 16;

  localparam int unsigned CTRL_IRQ_EN = 0;
  localparam int unsigned CTRL_FLUSH  = 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RESP  = 2'd1,
    ST_STALL = 2'd2
  } bus_state_t;

  // Assemble the read-only STATUS word from its fields.
  function automatic logic [31:0] pack_status(input logic       rx_nonempty,
                                              input logic       tx_full,
                                              input logic       irq_en,
                                              input logic       tx_ovf,
                                              input logic [7:0] rx_cnt,
                                              input logic [7:0] tx_cnt);
    logic [31:0] s;
    s = '0;
    s[STAT_RX_NONEMPTY]   = rx_nonempty;
    s[STAT_TX_FULL]       = tx_full;
    s[STAT_IRQ_EN]        = irq_en;
    s[STAT_TX_OVF]        = tx_ovf;
    s[STAT_RX_COUNT +: 8] = rx_cnt;
    s[STAT_TX_COUNT +: 8] = tx_cnt;
    return s;
  endfunction

endpackage

// File: rtl/picoramsoc_mailbox_fifo.sv
// Show-ahead synchronous FIFO with flush; push into a full FIFO is accepted
// only when a pop happens in the same cycle.
module picoramsoc_mailbox_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  logic [WIDTH-1:0]       wdata,
  output logic [WIDTH-1:0]       head,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr_q;
  logic [AW-1:0]    rptr_q;
  logic [CW-1:0]    count_q;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(DEPTH));
  assign do_pop  = pop && !empty && !flush;
  assign do_push = push && (!full || do_pop) && !flush;
  assign head    = mem[rptr_q];
  assign count   = count_q;

  // Pointers wrap naturally; flush wins over any same-cycle push/pop.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + AW'(1);
      if (do_pop)  rptr_q <= rptr_q + AW'(1);
      if (do_push && !do_pop) begin
        count_q <= count_q + CW'(1);
      end else if (do_pop && !do_push) begin
        count_q <= count_q - CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr_q] <= wdata;
  end

endmodule

// File: rtl/picoramsoc_mailbox.sv
// iomem-bus mailbox bridging firmware to TX/RX word streams with an RX irq.
// Optional MAILBOX_BLOCKING_EN: a DATA write to a full TX FIFO stalls instead of dropping.
module picoramsoc_mailbox
  import picoramsoc_mailbox_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0300_0000,
  parameter int unsigned DEPTH     = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        iomem_valid,
  output logic        iomem_ready,
  input  logic [3:0]  iomem_wstrb,
  input  logic [31:0] iomem_addr,
  input  logic [31:0] iomem_wdata,
  output logic [31:0] iomem_rdata,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic [31:0] tx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  input  logic [31:0] rx_data,
  output logic        irq
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  bus_state_t    state_q, state_d;
  logic          ready_q;
  logic [31:0]   rdata_q, rdata_d;
  logic          irq_en_q, irq_en_d;
  logic          ovf_q, ovf_d;
  logic          irq_q;
  logic          act, hit, is_wr, flush, tx_room;
  logic [31:0]   status;

  logic          tx_push, tx_pop, tx_full, tx_empty;
  logic [CW-1:0] tx_count;
  logic [31:0]   tx_head;
  logic          rx_push, rx_pop, rx_full, rx_empty;
  logic [CW-1:0] rx_count;
  logic [31:0]   rx_head;

  assign hit     = iomem_valid && (iomem_addr[31:4] == BASE_ADDR[31:4]);
  assign is_wr   = |iomem_wstrb;
  assign tx_pop  = !tx_empty && tx_ready;
  assign rx_push = rx_valid && !rx_full;
  assign tx_room = !tx_full || tx_pop;
  assign status  = pack_status(!rx_empty, tx_full, irq_en_q, ovf_q,
                               8'(rx_count), 8'(tx_count));

  assign iomem_ready = ready_q;
  assign iomem_rdata = rdata_q;
  assign tx_valid    = !tx_empty;
  assign tx_data     = tx_empty ? '0 : tx_head;
  assign rx_ready    = !rx_full;
  assign irq         = irq_q;

  // Bus FSM: decode and perform the access on the accepting edge.
  always_comb begin
    state_d  = state_q;
    act      = 1'b0;
    rdata_d  = '0;
    tx_push  = 1'b0;
    rx_pop   = 1'b0;
    flush    = 1'b0;
    irq_en_d = irq_en_q;
    ovf_d    = ovf_q;
    case (state_q)
      ST_IDLE: begin
        if (hit) begin
          act = 1'b1;
          case (iomem_addr[3:0])
            MBOX_DATA: begin
              if (!is_wr) begin
                rdata_d = rx_empty ? '0 : rx_head;
                rx_pop  = !rx_empty;
              end else if (iomem_wstrb == 4'hF) begin
                if (tx_room) begin
                  tx_push = 1'b1;
                end else begin
`ifdef MAILBOX_BLOCKING_EN
                  act     = 1'b0;
                  state_d = ST_STALL;
`else
                  ovf_d   = 1'b1;
`endif
                end
              end
            end
            MBOX_STATUS: begin
              if (!is_wr) rdata_d = status;
              else        ovf_d   = 1'b0;
            end
            MBOX_CTRL: begin
              if (!is_wr) begin
                rdata_d[CTRL_IRQ_EN] = irq_en_q;
              end else begin
                irq_en_d = iomem_wdata[CTRL_IRQ_EN];
                flush    = iomem_wdata[CTRL_FLUSH];
              end
            end
            default: ;
          endcase
        end
      end
      ST_RESP:  state_d = ST_IDLE;
      // Waiting for the sink to free a slot; push as it drains.
      ST_STALL: begin
        if (tx_pop) begin
          act     = 1'b1;
          tx_push = 1'b1;
        end
      end
      default:  state_d = ST_IDLE;
    endcase
    if (act) state_d = ST_RESP;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      ready_q  <= 1'b0;
      rdata_q  <= '0;
      irq_en_q <= 1'b0;
      ovf_q    <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      ready_q  <= act;
      rdata_q  <= act ? rdata_d : '0;
      irq_en_q <= irq_en_d;
      ovf_q    <= ovf_d;
      irq_q    <= irq_en_q && !rx_empty;
    end
  end

  picoramsoc_mailbox_fifo #(.DEPTH(DEPTH), .WIDTH(32)) u_tx_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (tx_push),
    .pop   (tx_pop),
    .flush (flush),
    .wdata (iomem_wdata),
    .head  (tx_head),
    .count (tx_count),
    .full  (tx_full),
    .empty (tx_empty)
  );

  picoramsoc_mailbox_fifo #(.DEPTH(DEPTH), .WIDTH(32)) u_rx_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (rx_push),
    .pop   (rx_pop),
    .flush (flush),
    .wdata (rx_data),
    .head  (rx_head),
    .count (rx_count),
    .full  (rx_full),
    .empty (rx_empty)
  );

endmodule

// File: tb/tb_picoramsoc_mailbox.sv
// Self-checking bench for picoramsoc_mailbox against a queue-based mailbox model.
// Honours MAILBOX_BLOCKING_EN when compiled with it.
module tb_picoramsoc_mailbox;

  localparam logic [31:0] BASE  = 32'h0300_0000;
  localparam int          DEPTH = 16;
  localparam int          TO    = 64;
`ifdef MAILBOX_BLOCKING_EN
  localparam bit BLOCKING = 1'b1;
`else
  localparam bit BLOCKING = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        iomem_valid;
  logic        iomem_ready;
  logic [3:0]  iomem_wstrb;
  logic [31:0] iomem_addr;
  logic [31:0] iomem_wdata;
  logic [31:0] iomem_rdata;
  logic        tx_valid;
  logic        tx_ready;
  logic [31:0] tx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [31:0] rx_data;
  logic        irq;

  always #5 clk = ~clk;

  picoramsoc_mailbox #(.BASE_ADDR(BASE), .DEPTH(DEPTH)) dut (
    .clk         (clk),
    .reset       (reset),
    .iomem_valid (iomem_valid),
    .iomem_ready (iomem_ready),
    .iomem_wstrb (iomem_wstrb),
    .iomem_addr  (iomem_addr),
    .iomem_wdata (iomem_wdata),
    .iomem_rdata (iomem_rdata),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .tx_data     (tx_data),
    .rx_valid    (rx_valid),
    .rx_ready    (rx_ready),
    .rx_data     (rx_data),
    .irq         (irq)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Mailbox model: two word queues plus control bits.
  logic [31:0] tx_q[$];
  logic [31:0] rx_q[$];
  bit          m_irq_en, m_ovf, m_irq, m_ready;
  logic [31:0] m_rdata;
  int          m_phase;  // 0 accepting, 1 responding, 2 waiting for TX space

  function automatic logic [31:0] m_tx_head();
    return (tx_q.size() != 0) ? tx_q[0] : 32'h0;
  endfunction

  // Apply one clock edge to the model with the currently driven inputs, then advance.
  task automatic tick();
    bit          hit, tx_pop, rx_push, act, stall, flush, bpush, bpop, irq_nx;
    logic [31:0] rd, st;
    hit     = iomem_valid && (iomem_addr[31:4] == BASE[31:4]);
    tx_pop  = tx_ready && (tx_q.size() != 0);
    rx_push = rx_valid && (rx_q.size() < DEPTH);
    act = 0; stall = 0; flush = 0; bpush = 0; bpop = 0; rd = '0;
    irq_nx  = m_irq_en && (rx_q.size() != 0);
    st = {8'h00, 8'(tx_q.size()), 8'(rx_q.size()), 4'h0, m_ovf, m_irq_en,
          tx_q.size() == DEPTH, rx_q.size() != 0};
    if (reset) begin
      tx_q.delete(); rx_q.delete();
      m_irq_en = 0; m_ovf = 0; m_irq = 0; m_ready = 0; m_rdata = '0; m_phase = 0;
    end else begin
      if (m_phase == 2) begin
        if (tx_pop) begin act = 1; bpush = 1; end
      end else if (m_phase == 0 && hit) begin
        act = 1;
        case (iomem_addr[3:0])
          4'h0: begin
            if (iomem_wstrb == 4'h0) begin
              if (rx_q.size() != 0) begin rd = rx_q[0]; bpop = 1; end
            end else if (iomem_wstrb == 4'hF) begin
              if (tx_q.size() < DEPTH || tx_pop) bpush = 1;
              else if (BLOCKING) begin act = 0; stall = 1; end
              else m_ovf = 1;
            end
          end
          4'h4: if (iomem_wstrb == 4'h0) rd = st; else m_ovf = 0;
          4'h8: begin
            if (iomem_wstrb == 4'h0) rd = {31'h0, m_irq_en};
            else begin m_irq_en = iomem_wdata[0]; flush = iomem_wdata[1]; end
          end
          default: ;
        endcase
      end
      m_irq = irq_nx;
      if (flush) begin
        tx_q.delete(); rx_q.delete();
      end else begin
        if (tx_pop)  tx_q.delete(0);
        if (bpush)   tx_q.push_back(iomem_wdata);
        if (bpop)    rx_q.delete(0);
        if (rx_push) rx_q.push_back(rx_data);
      end
      m_ready = act;
      m_rdata = act ? rd : '0;
      if (act)               m_phase = 1;
      else if (stall)        m_phase = 2;
      else if (m_phase == 1) m_phase = 0;
    end
    @(posedge clk);
    #1;
  endtask

  // One bus access held like a CPU would (valid stays up through the ready cycle).
  // rel > 0 pulses tx_ready for one cycle after rel cycles of waiting.
  task automatic bus_access(input logic [31:0] addr, input logic [3:0] strb,
                            input logic [31:0] wd, input int rel,
                            output logic [31:0] rd, output int lat,
                            output logic [31:0] exp_rd, output int exp_lat);
    int n;
    n = 0;
    iomem_valid = 1'b1; iomem_addr = addr; iomem_wstrb = strb; iomem_wdata = wd;
    rd = '0; exp_rd = '0; lat = TO; exp_lat = TO;
    while ((lat == TO || exp_lat == TO) && n < TO) begin
      if (rel > 0 && n == rel) tx_ready = 1'b1;
      else if (rel > 0 && n == rel + 1) tx_ready = 1'b0;
      tick();
      n++;
      if (iomem_ready && lat == TO)  begin lat = n;     rd = iomem_rdata; end
      if (m_ready && exp_lat == TO)  begin exp_lat = n; exp_rd = m_rdata; end
    end
    if (rel > 0) tx_ready = 1'b0;
    tick();
    iomem_valid = 1'b0; iomem_wstrb = 4'h0;
  endtask

  task automatic test_reset();
    logic [31:0] rd, erd;
    int lat, elat;
    reset = 1'b1;
    iomem_valid = 1'b1; iomem_addr = BASE; iomem_wstrb = 4'hF; iomem_wdata = 32'h1234_5678;
    repeat (3) tick();
    iomem_valid = 1'b0; iomem_wstrb = 4'h0; reset = 1'b0;
    tick();
    n_checks++;
    if ({iomem_ready, tx_valid, irq} !== 3'b000) begin
      n_fail++; $display("FAIL reset_outputs: got %b required 000", {iomem_ready, tx_valid, irq});
    end
    bus_access(BASE + 32'h4, 4'h0, 32'h0, 0, rd, lat, erd, elat);
    n_checks++;
    if (rd !== 32'h0 || lat !== 1) begin
      n_fail++; $display("FAIL reset_status: got %h lat %0d required 00000000 lat 1", rd, lat);
    end
    iomem_valid = 1'b1; iomem_addr = BASE + 32'h4; iomem_wstrb = 4'h0; reset = 1'b1;
    tick();
    reset = 1'b0; iomem_valid = 1'b0;
    n_checks++;
    if (iomem_ready !== 1'b0) begin
      n_fail++; $display("FAIL reset_abort: iomem_ready got %b required 0", iomem_ready);
    end
  endtask

  task automatic test_tx_write();
    logic [31:0] rd, erd;
    int lat, elat;
    tx_ready = 1'b0;
    bus_access(BASE, 4'hF, 32'hDEAD_BEEF, 0, rd, lat, erd, elat);
    n_checks++;
    if (lat !== 1 || tx_valid !== 1'b1 || tx_data !== 32'hDEAD_BEEF) begin
      n_fail++; $display("FAIL tx_write: lat %0d valid %b data %h required 1 1 deadbeef", lat, tx_valid, tx_data);
    end
    bus_access(BASE + 32'h4, 4'h0, 32'h0, 0, rd, lat, erd, elat);
    n_checks++;
    if (rd[23:16] !== 8'd1 || rd !== erd) begin
      n_fail++; $display("FAIL tx_count_one: got %h required %h", rd, erd);
    end
    tx_ready = 1'b1;
    tick();
    tx_ready = 1'b0;
    n_checks++;
    if (tx_valid !== 1'b0) begin
      n_fail++; $display("FAIL tx_drain: tx_valid got %b required 0", tx_valid);
    end
  endtask

  task automatic test_rx_irq();
    logic [31:0] rd, erd;
    int lat, elat;
    logic [31:0] exp_words [3];
    exp_words[0] = 32'h11; exp_words[1] = 32'h22; exp_words[2] = 32'h0;
    bus_access(BASE + 32'h8, 4'hF, 32'h1, 0, rd, lat, erd, elat);
    rx_valid = 1'b1; rx_data = 32'h11;
    tick();
    rx_valid = 1'b0;
    n_checks++;
    if (irq !== 1'b0 || irq !== m_irq) begin
      n_fail++; $display("FAIL irq_push_edge: got %b required 0", irq);
    end
    tick();
    n_checks++;
    if (irq !== 1'b1 || irq !== m_irq) begin
      n_fail++; $display("FAIL irq_rise: got %b required 1", irq);
    end
    rx_valid = 1'b1; rx_data = 32'h22;
    tick();
    rx_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus_access(BASE, 4'h0, 32'h0, 0, rd, lat, erd, elat);
      n_checks++;
      if (rd !== exp_words[i] || rd !== erd || lat !== 1) begin
        n_fail++; $display("FAIL rx_read%0d: got %h lat %0d required %h lat 1", i, rd, lat, exp_words[i]);
      end
    end
    n_checks++;
    if (irq !== 1'b0) begin
      n_fail++; $display("FAIL irq_fall: got %b required 0", irq);
    end
  endtask

  task automatic test_tx_full();
    logic [31:0] rd, erd;
    int lat, elat;
    tx_ready = 1'b0;
    bus_access(BASE + 32'h8, 4'hF, 32'h2, 0, rd, lat, erd, elat);
    for (int i = 0; i < DEPTH; i++) bus_access(BASE, 4'hF, $urandom, 0, rd, lat, erd, elat);
    bus_access(BASE + 32'h4, 4'h0, 32'h0, 0, rd, lat, erd, elat);
    n_checks++;
    if (rd[23:16] !== 8'd16 || rd[1] !== 1'b1 || rd !== erd) begin
      n_fail++; $display("FAIL tx_fill: status got %h required %h", rd, erd);
    end
    bus_access(BASE, 4'hF, 32'hA5A5_0017, BLOCKING ? 4 : 0, rd, lat, erd, elat);
    n_checks++;
    if (lat !== (BLOCKING ? 5 : 1) || lat !== elat) begin
      n_fail++; $display("FAIL tx_full_latency: got %0d required %0d", lat, BLOCKING ? 5 : 1);
    end
    bus_access(BASE + 32'h4, 4'h0, 32'h0, 0, rd, lat, erd, elat);
    n_checks++;
    if (rd[23:16] !== 8'd16 || rd[3] !== !BLOCKING || rd !== erd) begin
      n_fail++; $display("FAIL tx_full_status: got %h required %h", rd, erd);
    end
    tx_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      n_checks++;
      if (tx_valid !== 1'b1 || tx_data !== m_tx_head()) begin
        n_fail++; $display("FAIL tx_order%0d: got %b %h required 1 %h", i, tx_valid, tx_data, m_tx_head());
      end
      tick();
    end
    tx_ready = 1'b0;
    bus_access(BASE + 32'h4, 4'hF, 32'h0, 0, rd, lat, erd, elat);
    for (int i = 0; i < DEPTH; i++) bus_access(BASE, 4'hF, $urandom, 0, rd, lat, erd, elat);
    tx_ready = 1'b1;
    bus_access(BASE, 4'hF, 32'h5A5A_0001, 0, rd, lat, erd, elat);
    tx_ready = 1'b0;
    bus_access(BASE + 32'h4, 4'h0, 32'h0, 0, rd, lat, erd, elat);
    n_checks++;
    if (rd[23:16] !== 8'd15 || rd[3] !== 1'b0 || rd !== erd) begin
      n_fail++; $display("FAIL tx_full_drain_write: got %h required %h", rd, erd);
    end
    bus_access(BASE + 32'h8, 4'hF, 32'h2, 0, rd, lat, erd, elat);
  endtask

  task automatic test_rx_full();
    logic [31:0] rd, erd, first;
    int lat, elat;
    for (int i = 0; i < DEPTH; i++) begin
      rx_valid = 1'b1; rx_data = $urandom;
      tick();
    end
    first = rx_q[0];
    n_checks++;
    if (rx_ready !== 1'b0) begin
      n_fail++; $display("FAIL rx_full_ready: got %b required 0", rx_ready);
    end
    rx_data = 32'hCAFE_0001;
    bus_access(BASE, 4'h0, 32'h0, 0, rd, lat, erd, elat);
    rx_valid = 1'b0;
    n_checks++;
    if (rd !== first || rd !== erd) begin
      n_fail++; $display("FAIL rx_full_pop: got %h required %h", rd, first);
    end
    bus_access(BASE + 32'h4, 4'h0, 32'h0, 0, rd, lat, erd, elat);
    n_checks++;
    if (rd[15:8] !== 8'd16 || rd !== erd || rx_ready !== 1'b0) begin
      n_fail++; $display("FAIL rx_full_count: got %h rx_ready %b required %h 0", rd, rx_ready, erd);
    end
    bus_access(BASE + 32'h8, 4'hF, 32'h2, 0, rd, lat, erd, elat);
    bus_access(BASE + 32'h4, 4'h0, 32'h0, 0, rd, lat, erd, elat);
    n_checks++;
    if (rd[23:8] !== 16'h0 || rd !== erd) begin
      n_fail++; $display("FAIL flush_counts: got %h required %h", rd, erd);
    end
  endtask

  task automatic test_decode();
    logic [31:0] rd, erd;
    logic [31:0] miss [2];
    int lat, elat;
    miss[0] = 32'h0200_0008; miss[1] = BASE + 32'h10;
    for (int m = 0; m < 2; m++) begin
      iomem_valid = 1'b1; iomem_addr = miss[m]; iomem_wstrb = 4'h0;
      for (int i = 0; i < 3; i++) begin
        tick();
        n_checks++;
        if (iomem_ready !== 1'b0) begin
          n_fail++; $display("FAIL miss_ignored: addr %h ready got %b required 0", miss[m], iomem_ready);
        end
      end
      iomem_valid = 1'b0;
    end
    bus_access(BASE, 4'h1, 32'hAAAA_AAAA, 0, rd, lat, erd, elat);
    n_checks++;
    if (lat !== 1) begin
      n_fail++; $display("FAIL partial_strobe_ack: lat %0d required 1", lat);
    end
    bus_access(BASE + 32'h4, 4'h0, 32'h0, 0, rd, lat, erd, elat);
    n_checks++;
    if (rd[23:16] !== 8'd0 || rd !== erd) begin
      n_fail++; $display("FAIL partial_strobe_count: got %h required %h", rd, erd);
    end
    bus_access(BASE + 32'hC, 4'hF, 32'hFFFF_FFFF, 0, rd, lat, erd, elat);
    bus_access(BASE + 32'hC, 4'h0, 32'h0, 0, rd, lat, erd, elat);
    n_checks++;
    if (rd !== 32'h0 || lat !== 1) begin
      n_fail++; $display("FAIL reserved_read: got %h lat %0d required 00000000 lat 1", rd, lat);
    end
  endtask

  task automatic test_random();
    logic [31:0] rd, erd, addr, wd;
    logic [3:0]  strb;
    int lat, elat, op;
    for (int k = 0; k < 80; k++) begin
      repeat ($urandom_range(0, 3)) begin
        tx_ready = 1'($urandom); rx_valid = 1'($urandom); rx_data = $urandom;
        tick();
        n_checks++;
        if ({tx_valid, tx_data, rx_ready, irq} !==
            {tx_q.size() != 0, m_tx_head(), rx_q.size() < DEPTH, m_irq}) begin
          n_fail++;
          $display("FAIL rand_stream%0d: got %b %h %b %b required %b %h %b %b", k,
                   tx_valid, tx_data, rx_ready, irq,
                   tx_q.size() != 0, m_tx_head(), rx_q.size() < DEPTH, m_irq);
        end
      end
      op = int'($urandom_range(0, 9));
      wd = $urandom; strb = 4'h0; addr = BASE;
      if (op <= 3)      strb = 4'hF;
      else if (op == 7) addr = BASE + 32'h4;
      else if (op == 8) begin
        addr = BASE + 32'h8; strb = 4'hF;
        wd = {30'h0, $urandom_range(0, 7) == 0, 1'($urandom)};
      end else if (op == 9) begin addr = BASE + 32'h4; strb = 4'hF; end
      if (BLOCKING && op <= 3 && tx_q.size() == DEPTH) tx_ready = 1'b1;
      bus_access(addr, strb, wd, 0, rd, lat, erd, elat);
      n_checks++;
      if (lat !== elat || rd !== erd) begin
        n_fail++; $display("FAIL rand_bus%0d: op %0d got %h lat %0d required %h lat %0d", k, op, rd, lat, erd, elat);
      end
    end
    tx_ready = 1'b0; rx_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1; iomem_valid = 1'b0; iomem_wstrb = 4'h0; iomem_addr = '0; iomem_wdata = '0;
    tx_ready = 1'b0; rx_valid = 1'b0; rx_data = '0;
    m_irq_en = 0; m_ovf = 0; m_irq = 0; m_ready = 0; m_rdata = '0; m_phase = 0;
    test_reset();
    test_tx_write();
    test_rx_irq();
    test_tx_full();
    test_rx_full();
    test_decode();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
